// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain sequencer feeding a UART transmitter one strobe at a time.
// Optional synchronous FIFO clear via the `flush` port when UART_TX_FIFO_FLUSH_EN is defined.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic          tx_dv,
    output logic [7:0]    tx_byte,
    input  logic          tx_active,
    input  logic          tx_done,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic          flush,
`endif
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_WAIT_CLR  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            tx_dv_reg;
    logic [7:0]      tx_byte_reg;
    logic            push;
    logic            issue;
    logic            flush_int;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign wr_ready = !full;
    assign count    = count_reg;
    assign tx_dv    = tx_dv_reg;
    assign tx_byte  = tx_byte_reg;

    // A push coinciding with a flush is discarded along with the queue.
    assign push = wr_valid && wr_ready && !flush_int;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!empty && !tx_active) begin
                    issue      = 1'b1;
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    state_next = S_WAIT_CLR;
                end
            end
            // Waiting for tx_done to drop keeps a stale completion flag from
            // releasing the next byte early.
            S_WAIT_CLR: begin
                if (!tx_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            tx_dv_reg   <= 1'b0;
            tx_byte_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            tx_dv_reg <= issue;
            if (issue) begin
                tx_byte_reg <= mem[rd_ptr_reg];
            end
            // The issued byte is already captured above, so a flush only
            // has to discard what remains queued.
            if (flush_int) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (issue) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case ({push, issue})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4) with a simple transmitter model.
// Covers the flush port too when UART_TX_FIFO_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 6;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data  = 8'h00;
    logic          wr_ready;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_active;
    logic          tx_done  = 1'b0;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic          flush    = 1'b0;
`endif

    logic          hold_active = 1'b0;
    logic          model_busy  = 1'b0;
    logic          prev_dv     = 1'b0;
    int            busy_cnt    = 0;
    int            done_cnt    = 0;
    int            cyc         = 0;
    int            checks      = 0;
    int            failures    = 0;
    logic [7:0]    strobe_q [$];
    int            strobe_cyc_q [$];
    int            fall_q [$];

    assign tx_active = model_busy | hold_active;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: FRAME busy cycles per strobe, then tx_done high for 2 cycles.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (tx_dv) begin
            check("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
            strobe_q.push_back(tx_byte);
            strobe_cyc_q.push_back(cyc);
            $display("strobe cyc=%0d byte=%02h", cyc, tx_byte);
        end
        prev_dv = tx_dv;
        if (reset) begin
            model_busy = 1'b0;
            tx_done    = 1'b0;
            busy_cnt   = 0;
            done_cnt   = 0;
        end else if (tx_dv) begin
            model_busy = 1'b1;
            busy_cnt   = FRAME;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                model_busy = 1'b0;
                tx_done    = 1'b1;
                done_cnt   = 2;
            end
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                tx_done = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        strobe_q.delete();
        strobe_cyc_q.delete();
        fall_q.delete();
    endtask

    task automatic push_one(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk);
        wr_valid = 1'b0;
        $display("push byte=%02h count=%0d", b, count);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (strobe_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("strobe_timeout", {31'd0, strobe_q.size() >= n}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int rel_cyc;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single-byte latency into an idle, empty FIFO
        clear_logs();
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(negedge clk);
        wr_valid = 1'b0;
        check("lat_count_n1", count, 1);
        check("lat_dv_n1", tx_dv, 0);
        @(negedge clk);
        check("lat_dv_n2", tx_dv, 1);
        check("lat_byte_n2", tx_byte, 8'hA5);
        @(negedge clk);
        check("lat_dv_n3", tx_dv, 0);
        check("lat_count_n3", count, 0);
        repeat (20) @(negedge clk);

        // Fill to full while transmitter is held busy, then drain in order
        clear_logs();
        hold_active = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            @(negedge clk);
            $display("push byte=%02h count=%0d", 8'(i), count);
        end
        wr_data = 8'h05;
        check("full_flag", full, 1);
        check("full_wr_ready", wr_ready, 0);
        check("full_count", count, 4);
        @(negedge clk);
        wr_valid = 1'b0;
        check("full_reject_count", count, 4);
        check("full_no_dv", {31'd0, strobe_q.size() != 0}, 32'd0);
        clear_logs();
        hold_active = 1'b0;
        rel_cyc = cyc;
        wait_strobes(4, 200);
        for (int i = 0; i < strobe_q.size() && i < 4; i++) begin
            check($sformatf("drain_byte%0d", i), strobe_q[i], 8'(i + 1));
        end
        if (strobe_cyc_q.size() > 0) begin
            check("drain_first_gap", strobe_cyc_q[0] - rel_cyc, 1);
        end
        for (int i = 1; i < strobe_cyc_q.size() && i <= fall_q.size(); i++) begin
            gap = strobe_cyc_q[i] - fall_q[i - 1];
            check($sformatf("drain_gap%0d", i), {31'd0, (gap >= 1 && gap <= 2)}, 32'd1);
        end
        repeat (30) @(negedge clk);
        check("drain_total", strobe_q.size(), 4);
        check("drain_count", count, 0);
        check("drain_empty", empty, 1);

        // Push in the same cycle as an issue with count=1
        clear_logs();
        hold_active = 1'b1;
        push_one(8'h11);
        check("pp_count_pre", count, 1);
        @(negedge clk);
        hold_active = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        @(negedge clk);
        wr_valid = 1'b0;
        check("pp_count_same", count, 1);
        check("pp_dv", tx_dv, 1);
        check("pp_byte", tx_byte, 8'h11);
        wait_strobes(2, 100);
        if (strobe_q.size() >= 2) begin
            check("pp_next_byte", strobe_q[1], 8'h3C);
        end
        repeat (20) @(negedge clk);

        // Transmitter busy for 50 cycles holds off the strobe
        clear_logs();
        hold_active = 1'b1;
        push_one(8'h77);
        repeat (50) @(negedge clk);
        check("hold_no_dv", strobe_q.size(), 0);
        check("hold_count", count, 1);
        hold_active = 1'b0;
        @(negedge clk);
        check("hold_release_dv", tx_dv, 1);
        check("hold_release_byte", tx_byte, 8'h77);
        repeat (20) @(negedge clk);

`ifdef UART_TX_FIFO_FLUSH_EN
        // Flush with one byte in flight and three queued
        clear_logs();
        push_one(8'hAA);
        push_one(8'hBB);
        push_one(8'hCC);
        push_one(8'hDD);
        check("fl_count_pre", count, 3);
        check("fl_busy_pre", tx_active, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        repeat (40) @(negedge clk);
        check("fl_frame_done", fall_q.size(), 1);
        check("fl_strobes", strobe_q.size(), 1);
`endif

        // Reset mid-frame with three bytes queued
        clear_logs();
        push_one(8'h21);
        push_one(8'h22);
        push_one(8'h23);
        push_one(8'h24);
        check("mr_count_pre", count, 3);
        check("mr_busy_pre", tx_active, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_count", count, 0);
        check("mr_empty", empty, 1);
        check("mr_wr_ready", wr_ready, 1);
        check("mr_tx_dv", tx_dv, 0);
        check("mr_tx_byte", tx_byte, 8'h00);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mr_no_more_dv", strobe_q.size(), 1);
        check("mr_count_after", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
